// File: rtl/full_subtractor_pkg.sv
// full_subtractor_pkg: width limit and {bout, diff} reference shared by the subtractor and its checks
package full_subtractor_pkg;

    localparam int WIDTH_MAX = 64;

    function automatic logic [WIDTH_MAX:0] fs_ref(
        input int unsigned            w,
        input logic [WIDTH_MAX-1:0]   a,
        input logic [WIDTH_MAX-1:0]   b,
        input logic                   bin
    );
        logic [WIDTH_MAX-1:0] mask;
        logic [WIDTH_MAX:0]   sub;
        mask = (w >= WIDTH_MAX) ? '1 : (WIDTH_MAX'(1) << w) - WIDTH_MAX'(1);
        sub  = {1'b0, a & mask} - {1'b0, b & mask} - (WIDTH_MAX+1)'(bin);
        return {sub[WIDTH_MAX], sub[WIDTH_MAX-1:0] & mask};
    endfunction

endpackage

// File: rtl/full_subtractor_cell.sv
// full_subtractor_cell: 1-bit borrow cell; FULL_SUBTRACTOR_NOR_ONLY_EN selects a 2-input-NOR-only netlist
module full_subtractor_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);
`ifdef FULL_SUBTRACTOR_NOR_ONLY_EN
    logic n1, n2, n3, axb_n, axb;
    logic m1, m2, m3, diff_n;
    logic b_n, bin_n, p, q, bo_n;
    nor g0  (n1, a, b);
    nor g1  (n2, a, n1);
    nor g2  (n3, b, n1);
    nor g3  (axb_n, n2, n3);
    nor g4  (axb, axb_n, axb_n);
    nor g5  (m1, axb, bin);
    nor g6  (m2, axb, m1);
    nor g7  (m3, bin, m1);
    nor g8  (diff_n, m2, m3);
    nor g9  (diff, diff_n, diff_n);
    // p = ~a & b, q = ~(a ^ b) & bin, bout = p | q
    nor g10 (b_n, b, b);
    nor g11 (p, a, b_n);
    nor g12 (bin_n, bin, bin);
    nor g13 (q, axb, bin_n);
    nor g14 (bo_n, p, q);
    nor g15 (bout, bo_n, bo_n);
`else
    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
`endif
endmodule

// File: rtl/full_subtractor.sv
// full_subtractor: registered ripple-borrow a - b - bin; cell style set by FULL_SUBTRACTOR_NOR_ONLY_EN
module full_subtractor
    import full_subtractor_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             out_valid
);
    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] diff_c, diff_d, diff_q;
    logic             bout_d, bout_q, out_valid_d, out_valid_q;

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("full_subtractor: WIDTH out of range");
    end

    assign br[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_subtractor_cell u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (br[i]),
            .diff (diff_c[i]),
            .bout (br[i+1])
        );
    end

    always_comb begin
        diff_d      = in_valid ? diff_c    : diff_q;
        bout_d      = in_valid ? br[WIDTH] : bout_q;
        out_valid_d = in_valid;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_valid)
            assert (fs_ref(WIDTH, WIDTH_MAX'(a), WIDTH_MAX'(b), bin) == {br[WIDTH], WIDTH_MAX'(diff_c)})
            else $error("full_subtractor: ripple chain disagrees with fs_ref");
    end

    assign diff      = diff_q;
    assign bout      = bout_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_full_subtractor.sv
// tb_full_subtractor: scoreboard bench driving WIDTH=1, 8 and 64 instances against an arithmetic model
module tb_full_subtractor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        iv1 = 0, a1 = 0, b1 = 0, bin1 = 0, d1, bo1, ov1;
    logic        iv8 = 0, bin8 = 0, bo8, ov8;
    logic [7:0]  a8 = 0, b8 = 0, d8;
    logic        iv64 = 0, bin64 = 0, bo64, ov64;
    logic [63:0] a64 = 0, b64 = 0, d64;

    full_subtractor #(.WIDTH(1)) u_w1 (.clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .bin(bin1),
        .diff(d1), .bout(bo1), .out_valid(ov1));
    full_subtractor #(.WIDTH(8)) u_w8 (.clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .diff(d8), .bout(bo8), .out_valid(ov8));
    full_subtractor #(.WIDTH(64)) u_w64 (.clk(clk), .rst(rst), .in_valid(iv64), .a(a64), .b(b64), .bin(bin64),
        .diff(d64), .bout(bo64), .out_valid(ov64));

    int errors = 0;
    int checks = 0;
    logic [64:0] q1[$], q8[$], q64[$];

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: out_valid high with no result outstanding", name);
    endtask

    // {bout, diff}: diff is (2^w + a - b - bin) mod 2^w, bout is set when that sum did not reach 2^w
    function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin);
        logic [65:0] t;
        logic [63:0] m;
        m = (w == 64) ? '1 : (64'd1 << w) - 64'd1;
        t = (66'd1 << w) + {2'b0, a & m} - {2'b0, b & m} - {65'd0, bin};
        return {~t[w], t[63:0] & m};
    endfunction

    always @(negedge clk) if (ov1) begin
        if (q1.size() == 0) unexpected("w1_out");
        else chk("w1_out", {bo1, 63'd0, d1}, q1.pop_front());
    end
    always @(negedge clk) if (ov8) begin
        if (q8.size() == 0) unexpected("w8_out");
        else chk("w8_out", {bo8, 56'd0, d8}, q8.pop_front());
    end
    always @(negedge clk) if (ov64) begin
        if (q64.size() == 0) unexpected("w64_out");
        else chk("w64_out", {bo64, d64}, q64.pop_front());
    end

    task automatic send(input int w, input logic [63:0] a, input logic [63:0] b, input logic bin,
                        input logic [64:0] exp);
        @(posedge clk);
        #1;
        iv1 = (w == 1);
        iv8 = (w == 8);
        iv64 = (w == 64);
        if (w == 1) begin a1 = a[0]; b1 = b[0]; bin1 = bin; q1.push_back(exp); end
        else if (w == 8) begin a8 = a[7:0]; b8 = b[7:0]; bin8 = bin; q8.push_back(exp); end
        else begin a64 = a; b64 = b; bin64 = bin; q64.push_back(exp); end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        iv1 = 0; iv8 = 0; iv64 = 0;
    endtask

    logic [1:0] sweep_exp [8];

    initial begin
        sweep_exp = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
        #1 rst = 1'b1;
        #2;
        chk("reset_w1", {62'd0, ov1, d1, bo1}, 65'd0);
        chk("reset_w8", {55'd0, ov8, d8, bo8}, 65'd0);
        chk("reset_w64", {ov64, d64}, 65'd0);
        chk("reset_w64_bout", {64'd0, bo64}, 65'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            send(1, {63'd0, v[2]}, {63'd0, v[1]}, v[0], {sweep_exp[k][0], 63'd0, sweep_exp[k][1]});
        end
        idle();

        send(8, 64'h5A, 64'h5A, 1'b0, {1'b0, 64'h00});
        send(8, 64'hFF, 64'h00, 1'b0, {1'b0, 64'hFF});
        send(8, 64'h00, 64'h00, 1'b1, {1'b1, 64'hFF});
        idle();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            if (k % 2 == 0) begin a8 = 'x; b8 = 'x; bin8 = 1'bx; end
            else begin a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom); end
            #3;
            chk($sformatf("hold_w8_%0d", k), {55'd0, ov8, d8, bo8}, {55'd0, 1'b0, 8'hFF, 1'b1});
        end

        send(1, 64'd0, 64'd0, 1'b1, {1'b1, 64'd1});
        @(posedge clk);
        #1;
        a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_w1", {62'd0, ov1, d1, bo1}, 65'd0);
        chk("midreset_w8", {55'd0, ov8, d8, bo8}, 65'd0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        q1.push_back({1'b0, 64'd1});
        idle();

        for (int k = 0; k < 1000; k++) begin
            logic [63:0] ra, rb;
            logic rbin;
            ra = 64'($urandom_range(0, 255));
            rb = 64'($urandom_range(0, 255));
            rbin = 1'($urandom);
            send(8, ra, rb, rbin, model(8, ra, rb, rbin));
        end
        idle();

        send(64, 64'd0, 64'd1, 1'b0, {1'b1, {64{1'b1}}});
        send(64, 64'd0, 64'd0, 1'b1, {1'b1, {64{1'b1}}});
        send(64, {64{1'b1}}, 64'd0, 1'b0, {1'b0, {64{1'b1}}});
        for (int k = 0; k < 50; k++) begin
            logic [63:0] ra, rb;
            logic rbin;
            ra = {$urandom, $urandom};
            rb = (k % 5 == 0) ? ra : {$urandom, $urandom};
            rbin = 1'($urandom);
            send(64, ra, rb, rbin, model(64, ra, rb, rbin));
        end
        for (int k = 0; k < 20; k++) begin
            logic [63:0] ra, rb;
            logic rbin;
            ra = 64'($urandom_range(0, 1));
            rb = 64'($urandom_range(0, 1));
            rbin = 1'($urandom);
            send(1, ra, rb, rbin, model(1, ra, rb, rbin));
        end
        idle();
        repeat (3) @(posedge clk);
        chk("queues_drained", 65'(q1.size() + q8.size() + q64.size()), 65'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
